// File: rtl/stdp_pkg.sv
// Shared types and default sizes for the STDP epoch scheduler and its write-back pipe.
package stdp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      SWEEP,
      DRAIN,
      DONE
   } sched_state_t;

   localparam int NUM_SYN_DEF  = 16;
   localparam int ADDR_W_DEF   = 4;
   localparam int WINDOW_DEF   = 16;
   localparam int PIPE_LAT_DEF = 2;

   // Terminal value of a 5-bit phase counter that runs 0..n-1.
   function automatic logic [4:0] lastCount(input int n);
      return 5'(n - 1);
   endfunction

endpackage

// File: rtl/stdp_wb_pipe.sv
// PIPE_LAT-deep {valid, addr} delay line; the whole line freezes while i_enable is low.
module stdp_wb_pipe #(
   parameter int ADDR_W   = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr
);

   logic              r_valid [PIPE_LAT];
   logic [ADDR_W-1:0] r_addr  [PIPE_LAT];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            r_valid[i] <= 1'b0;
            r_addr[i]  <= '0;
         end
      end else if (i_enable) begin
         r_valid[0] <= i_valid;
         r_addr[0]  <= i_addr;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_addr[i]  <= r_addr[i-1];
         end
      end
   end

   assign o_valid = r_valid[PIPE_LAT-1];
   assign o_addr  = r_addr[PIPE_LAT-1];

endmodule

// File: rtl/stdp_update_scheduler.sv
// Sequences one STDP epoch: spike sampling window, then a read-modify-write sweep of all
// weights whose write-back is gated by the reward level captured at the end of sampling.
module stdp_update_scheduler
   import stdp_pkg::*;
#(
   parameter int NUM_SYN      = NUM_SYN_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int WINDOW       = WINDOW_DEF,
   parameter int PIPE_LAT     = PIPE_LAT_DEF,
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_start,
   input  logic              i_reward_flag,
   output logic              o_sample_en,
   output logic [4:0]        o_sample_idx,
   output logic              o_re,
   output logic [ADDR_W-1:0] o_read_addr,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_write_addr,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W:0]   o_writes_cnt
);

   sched_state_t      r_state;
   sched_state_t      w_nextState;
   logic [4:0]        r_cnt;
   logic [4:0]        w_nextCnt;
   logic              r_rewardQ;
   logic [ADDR_W:0]   r_writeAcc;
   logic [ADDR_W:0]   r_writesCnt;
   logic              w_pipeValid;
   logic              w_epochStart;
   logic              w_samplePoint;

   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      o_sample_en  = 1'b0;
      o_sample_idx = '0;
      o_re         = 1'b0;
      o_read_addr  = '0;
      o_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start && i_enable) begin
               w_nextState = SAMPLE;
               w_nextCnt   = '0;
            end
         end
         SAMPLE: begin
            o_sample_en  = i_enable;
            o_sample_idx = r_cnt;
            if (i_enable) begin
               if (r_cnt == lastCount(WINDOW)) begin
                  w_nextState = SWEEP;
                  w_nextCnt   = '0;
               end else begin
                  w_nextCnt = r_cnt + 5'd1;
               end
            end
         end
         SWEEP: begin
            o_re        = i_enable;
            o_read_addr = r_cnt[ADDR_W-1:0];
            if (i_enable) begin
               if (r_cnt == lastCount(NUM_SYN)) begin
                  w_nextState = DRAIN;
                  w_nextCnt   = '0;
               end else begin
                  w_nextCnt = r_cnt + 5'd1;
               end
            end
         end
         DRAIN: begin
            // Wait out the pipeline so the last read's write has issued before DONE.
            if (i_enable) begin
               if (r_cnt == lastCount(PIPE_LAT)) begin
                  w_nextState = DONE;
                  w_nextCnt   = '0;
               end else begin
                  w_nextCnt = r_cnt + 5'd1;
               end
            end
         end
         DONE: begin
            o_done = i_enable;
            if (i_enable) begin
               w_nextState = AUTO_RESTART ? SAMPLE : IDLE;
               w_nextCnt   = '0;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   assign w_epochStart  = (w_nextState == SAMPLE) && (r_state != SAMPLE);
   assign w_samplePoint = (r_state == SAMPLE) && i_enable && (r_cnt == lastCount(WINDOW));

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rewardQ   <= 1'b0;
         r_writeAcc  <= '0;
         r_writesCnt <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         if (w_samplePoint) begin
            r_rewardQ <= i_reward_flag;
         end
         if (w_epochStart) begin
            r_writeAcc <= '0;
         end else if (o_we) begin
            r_writeAcc <= r_writeAcc + 1'b1;
         end
         if ((r_state == DONE) && i_enable) begin
            r_writesCnt <= r_writeAcc;
         end
      end
   end

   stdp_wb_pipe #(
      .ADDR_W   (ADDR_W),
      .PIPE_LAT (PIPE_LAT)
   ) u_wbPipe (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_enable (i_enable),
      .i_valid  (o_re),
      .i_addr   (o_read_addr),
      .o_valid  (w_pipeValid),
      .o_addr   (o_write_addr)
   );

   assign o_we         = w_pipeValid && r_rewardQ && i_enable;
   assign o_busy       = (r_state != IDLE);
   assign o_writes_cnt = r_writesCnt;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench: epoch timing, reward gating, enable gap, ignored starts, reset abort, auto-restart.
module tb_stdp_update_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       aEnable, aStart, aReward;
   logic       bEnable, bStart, bReward;

   logic       aSampleEn, aRe, aWe, aBusy, aDone;
   logic [4:0] aSampleIdx, aWritesCnt;
   logic [3:0] aReadAddr, aWriteAddr;
   logic       bSampleEn, bRe, bWe, bBusy, bDone;
   logic [4:0] bSampleIdx, bWritesCnt;
   logic [3:0] bReadAddr, bWriteAddr;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   stdp_update_scheduler dutA (
      .i_clk(clk), .i_rst(rst), .i_enable(aEnable), .i_start(aStart), .i_reward_flag(aReward),
      .o_sample_en(aSampleEn), .o_sample_idx(aSampleIdx), .o_re(aRe), .o_read_addr(aReadAddr),
      .o_we(aWe), .o_write_addr(aWriteAddr), .o_busy(aBusy), .o_done(aDone),
      .o_writes_cnt(aWritesCnt)
   );

   stdp_update_scheduler #(.AUTO_RESTART(1'b1)) dutB (
      .i_clk(clk), .i_rst(rst), .i_enable(bEnable), .i_start(bStart), .i_reward_flag(bReward),
      .o_sample_en(bSampleEn), .o_sample_idx(bSampleIdx), .o_re(bRe), .o_read_addr(bReadAddr),
      .o_we(bWe), .o_write_addr(bWriteAddr), .o_busy(bBusy), .o_done(bDone),
      .o_writes_cnt(bWritesCnt)
   );

   task automatic applyStimulus(input logic enable, input logic start, input logic reward);
      aEnable = enable;
      aStart  = start;
      aReward = reward;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // e is the 1-based count of enabled cycles since start; e=35 is the DONE cycle.
   task automatic checkCycle(input bit sel, input int e, input bit en, input bit rq);
      bit inSample, inSweep, inWrite;
      inSample = (e >= 1) && (e <= 16);
      inSweep  = (e >= 17) && (e <= 32);
      inWrite  = (e >= 19) && (e <= 34);
      checkOutput($sformatf("sample_en e=%0d", e), sel ? bSampleEn : aSampleEn, en && inSample);
      checkOutput($sformatf("sample_idx e=%0d", e), sel ? bSampleIdx : aSampleIdx, inSample ? e - 1 : 0);
      checkOutput($sformatf("re e=%0d", e), sel ? bRe : aRe, en && inSweep);
      checkOutput($sformatf("read_addr e=%0d", e), sel ? bReadAddr : aReadAddr, inSweep ? e - 17 : 0);
      checkOutput($sformatf("we e=%0d", e), sel ? bWe : aWe, en && rq && inWrite);
      checkOutput($sformatf("write_addr e=%0d", e), sel ? bWriteAddr : aWriteAddr, inWrite ? e - 19 : 0);
      checkOutput($sformatf("done e=%0d", e), sel ? bDone : aDone, en && (e == 35));
      checkOutput($sformatf("busy e=%0d", e), sel ? bBusy : aBusy, 1);
   endtask

   task automatic checkIdleA(input string tag, input int expWrites);
      checkOutput({tag, " busy"}, aBusy, 0);
      checkOutput({tag, " done"}, aDone, 0);
      checkOutput({tag, " sample_en"}, aSampleEn, 0);
      checkOutput({tag, " re"}, aRe, 0);
      checkOutput({tag, " we"}, aWe, 0);
      checkOutput({tag, " writes_cnt"}, aWritesCnt, expWrites);
   endtask

   task automatic runEpoch(input bit rewardSample, input int gapAt, input int gapLen,
                           input bit extraStarts, input int expWrites);
      @(negedge clk);
      applyStimulus(1, 1, 1);
      #1 checkOutput("pre-start busy", aBusy, 0);
      for (int e = 1; e <= 38; e++) begin
         if (e == gapAt) begin
            for (int g = 0; g < gapLen; g++) begin
               @(negedge clk);
               applyStimulus(0, 0, 1);
               #1 checkCycle(0, e, 0, rewardSample);
            end
         end
         @(negedge clk);
         applyStimulus(1, extraStarts && (e == 5 || e == 35), (e == 16) ? rewardSample : 1'b1);
         #1;
         if (e <= 35) checkCycle(0, e, 1, rewardSample);
         else checkIdleA($sformatf("idle e=%0d", e), expWrites);
      end
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1, 0, 0);
      bEnable = 1'b1; bStart = 1'b0; bReward = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkIdleA("reset A", 0);
      checkOutput("reset A idx", aSampleIdx, 0);
      checkOutput("reset A read_addr", aReadAddr, 0);
      checkOutput("reset A write_addr", aWriteAddr, 0);
      checkOutput("reset B busy", bBusy, 0);

      $display("[TB] nominal epoch with reward");
      runEpoch(1, 0, 0, 0, 16);

      $display("[TB] reward low at sample point");
      runEpoch(0, 0, 0, 0, 0);

      $display("[TB] enable gap at read_addr 4");
      runEpoch(1, 21, 5, 0, 16);

      $display("[TB] start pulses in SAMPLE and DONE");
      runEpoch(1, 0, 0, 1, 16);

      $display("[TB] reset mid-sweep");
      @(negedge clk);
      applyStimulus(1, 1, 1);
      for (int e = 1; e <= 24; e++) begin
         @(negedge clk);
         applyStimulus(1, 0, 1);
      end
      #1 checkOutput("pre-reset read_addr", aReadAddr, 7);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkIdleA("post-reset", 0);
      checkOutput("post-reset read_addr", aReadAddr, 0);
      checkOutput("post-reset write_addr", aWriteAddr, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 checkIdleA($sformatf("post-reset c=%0d", c), 0);
      end

      $display("[TB] auto restart");
      @(negedge clk);
      bStart = 1'b1;
      for (int ep = 0; ep < 2; ep++) begin
         for (int e = 1; e <= 35; e++) begin
            @(negedge clk);
            bStart = 1'b0;
            #1 checkCycle(1, e, 1, 1);
            if (ep == 1 && e == 1) checkOutput("auto writes_cnt", bWritesCnt, 16);
         end
      end
      @(negedge clk);
      #1;
      checkOutput("auto restart sample_en", bSampleEn, 1);
      checkOutput("auto restart idx", bSampleIdx, 0);
      checkOutput("auto restart busy", bBusy, 1);
      checkOutput("auto restart writes_cnt", bWritesCnt, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
